rom_string_streamer: RTL

Sequencing reader for the combinational character ROMs (4-bit address, 8-bit ASCII data). On a start pulse it walks the ROM from address 0 and presents each character on a valid/ready byte stream toward the display/serial transmit path. It stops at the terminator byte or at the last address, then reports completion and the character count. It sits between a ROM instance and any byte consumer, such as a UART TX or an LCD writer.

---
 rtl/rom_string_streamer.sv | 94 +++++++++
 1 files changed

// File: rtl/rom_string_streamer.sv
// Sequencing reader for a combinational character ROM: walks addresses from 0 on start,
// streams each character over valid/ready, stops at the terminator or the last address.
module rom_string_streamer #(
  parameter int unsigned          ADDR_W = 4,
  parameter int unsigned          DATA_W = 8,
  parameter logic [DATA_W-1:0]    TERM   = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else if (abort) begin
      // count is left alone so the caller can see how far the stream got
      state    <= IDLE;
      rom_addr <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            rom_addr <= '0;
            count    <= '0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (rom_data == TERM) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tx_data  <= rom_data;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            count    <= count + 1'b1;
            tx_valid <= 1'b0;
            // last address ends the stream without wrapping rom_addr
            if (rom_addr == '1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
